// File: rtl/carfield_pkg.sv
// Carfield SCMI mailbox shared definitions: window placement, register map,
// channel stride and the per-channel control state type.
package carfield_pkg;

    localparam logic [31:0] ScmiMailboxBase = 32'h4000_0000;
    localparam logic [31:0] ScmiMailboxSize = 32'h0000_1000;
    localparam logic [11:0] ChannelStride   = 12'h040;

    typedef enum logic [5:0] {
        REG_STATUS     = 6'h00,
        REG_DOORBELL   = 6'h04,
        REG_COMPLETION = 6'h08,
        REG_FLAGS      = 6'h0C,
        REG_PAYLOAD0   = 6'h10
    } mbox_reg_e;

    typedef struct packed {
        logic channel_free;
        logic doorbell_pending;
        logic completion_pending;
        logic irq_en;
    } chan_state_t;

    localparam chan_state_t ChanStateRst = '{
        channel_free:       1'b1,
        doorbell_pending:   1'b0,
        completion_pending: 1'b0,
        irq_en:             1'b0
    };

endpackage

// File: rtl/carfield_mailbox_channel.sv
// One SCMI mailbox channel: control/pending flops, optional payload words
// (CARFIELD_MBOX_PAYLOAD_EN) and the channel's read mux.
module carfield_mailbox_channel
    import carfield_pkg::*;
#(
    parameter int unsigned PayloadWords = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [5:0]  reg_i,
    input  logic [31:0] wdata_i,
    output logic        doorbell_irq_o,
    output logic        completion_irq_o,
    output logic [31:0] rdata_o
);

    chan_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (we_i) begin
            case (reg_i)
                REG_DOORBELL: begin
                    state_d.doorbell_pending = wdata_i[0];
                    if (wdata_i[0]) state_d.channel_free = 1'b0;
                end
                REG_COMPLETION: begin
                    state_d.completion_pending = wdata_i[0];
                    // Agent hands the channel back: host may reuse it.
                    if (wdata_i[0]) begin
                        state_d.channel_free     = 1'b1;
                        state_d.doorbell_pending = 1'b0;
                    end
                end
                REG_FLAGS: state_d.irq_en = wdata_i[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ChanStateRst;
        else         state_q <= state_d;
    end

    assign doorbell_irq_o   = state_q.doorbell_pending;
    assign completion_irq_o = state_q.completion_pending & state_q.irq_en;

`ifdef CARFIELD_MBOX_PAYLOAD_EN
    logic [PayloadWords-1:0][31:0] payload_q, payload_d;

    always_comb begin
        payload_d = payload_q;
        if (we_i) begin
            for (int w = 0; w < PayloadWords; w++) begin
                if (reg_i == 6'(REG_PAYLOAD0) + 6'(4 * w)) payload_d[w] = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) payload_q <= '0;
        else         payload_q <= payload_d;
    end
`else
    logic [31:0] unused_wdata;
    assign unused_wdata = {wdata_i[31:1], 1'b0} ^ 32'(PayloadWords);
`endif

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            REG_STATUS:     rdata_o[0] = state_q.channel_free;
            REG_DOORBELL:   rdata_o[0] = state_q.doorbell_pending;
            REG_COMPLETION: rdata_o[0] = state_q.completion_pending;
            REG_FLAGS:      rdata_o[0] = state_q.irq_en;
            default: ;
        endcase
`ifdef CARFIELD_MBOX_PAYLOAD_EN
        for (int w = 0; w < PayloadWords; w++) begin
            if (reg_i == 6'(REG_PAYLOAD0) + 6'(4 * w)) rdata_o = payload_q[w];
        end
`endif
    end

endmodule

// File: rtl/carfield_mailbox_unit.sv
// Carfield SCMI mailbox: valid/ready register window over NumChannels channels.
// Payload storage is present only with CARFIELD_MBOX_PAYLOAD_EN defined.
module carfield_mailbox_unit
    import carfield_pkg::*;
#(
    parameter int unsigned NumChannels  = 2,
    parameter int unsigned PayloadWords = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [11:0]            req_addr_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_error_o,
    output logic [NumChannels-1:0] doorbell_irq_o,
    output logic [NumChannels-1:0] completion_irq_o
);

`ifdef CARFIELD_MBOX_PAYLOAD_EN
    localparam bit PayloadEn = 1'b1;
`else
    localparam bit PayloadEn = 1'b0;
`endif

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    logic        accept;
    logic [5:0]  ch;
    logic [5:0]  off;
    logic        ch_ok, payload_hit, mapped, err;
    logic [31:0] rd_sel;

    logic [NumChannels-1:0] we;
    logic [31:0]            ch_rdata [NumChannels];

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    assign ch  = req_addr_i[11:6];
    assign off = req_addr_i[5:0];

    assign ch_ok       = 32'(ch) < NumChannels;
    assign payload_hit = (off >= 6'(REG_PAYLOAD0)) &&
                         (((32'(off) - 32'h10) >> 2) < PayloadWords);
    // Aligned offsets below 0x10 are exactly the four control registers.
    assign mapped      = (off < 6'(REG_PAYLOAD0)) || (PayloadEn && payload_hit);
    assign err         = !ch_ok || (off[1:0] != 2'b00) || !mapped ||
                         (req_write_i && off == 6'(REG_STATUS));

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        assign we[c] = accept && req_write_i && !err && (ch == 6'(c));

        carfield_mailbox_channel #(
            .PayloadWords (PayloadWords)
        ) u_ch (
            .clk_i            (clk_i),
            .rst_ni           (rst_ni),
            .we_i             (we[c]),
            .reg_i            (off),
            .wdata_i          (req_wdata_i),
            .doorbell_irq_o   (doorbell_irq_o[c]),
            .completion_irq_o (completion_irq_o[c]),
            .rdata_o          (ch_rdata[c])
        );
    end

    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (ch == 6'(c)) rd_sel = ch_rdata[c];
        end
    end

    // Read data is sampled from the pre-edge state, so it never sees its own
    // cycle's write; writes and errors return zero.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = err;
            rsp_rdata_d = (err || req_write_i) ? 32'h0 : rd_sel;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;

endmodule
